// File: rtl/rtc_bus_pkg.sv
// rtc_bus_pkg: shared states, default timing and pin idle levels for the RTC bus transactor
package rtc_bus_pkg;
  typedef enum logic [3:0] {
    IDLE = 4'd0,
    A_SU = 4'd1,
    A_PW = 4'd2,
    A_H  = 4'd3,
    D_SU = 4'd4,
    D_PW = 4'd5,
    D_H  = 4'd6,
    DONE = 4'd7,
    REC  = 4'd8
  } state_t;
  localparam int T_SU_DEF  = 2;
  localparam int T_PW_DEF  = 5;
  localparam int T_H_DEF   = 2;
  localparam int T_REC_DEF = 3;
  localparam logic PIN_IDLE = 1'b1;
  function automatic logic [7:0] ticks(input int t);
    return 8'(t - 1);
  endfunction
endpackage

// File: rtl/rtc_bus_timer.sv
// rtc_bus_timer: 8-bit loadable down-counter that stops at zero
//   clk, reset (async, active-high), load, load_val[7:0] -> zero
module rtc_bus_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       zero
);
  logic [7:0] cnt;
  assign zero = cnt == 8'd0;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= 8'd0;
    else if (load) cnt <= load_val;
    else if (!zero) cnt <= cnt - 8'd1;
endmodule

// File: rtl/rtc_bus_transactor.sv
// rtc_bus_transactor: one RTC multiplexed-bus transaction (address cycle then data cycle) per request
//   in : clk, reset (async, active-high), in_en_funcion_rtc, in_funcion_w_r,
//        in_addr_ram_rtc[7:0], in_dato_escritura[7:0], in_ad_bus[7:0]
//   out: out_ad_bus[7:0], out_ad_oe, out_cs_n, out_ad_n, out_wr_n, out_rd_n,
//        out_dato_leido[7:0], out_flag_done
//   RTC_ABORT_EN: when defined, dropping en during the address cycle abandons the transaction
module rtc_bus_transactor
  import rtc_bus_pkg::*;
#(
  parameter int T_SU  = T_SU_DEF,
  parameter int T_PW  = T_PW_DEF,
  parameter int T_H   = T_H_DEF,
  parameter int T_REC = T_REC_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_en_funcion_rtc,
  input  logic       in_funcion_w_r,
  input  logic [7:0] in_addr_ram_rtc,
  input  logic [7:0] in_dato_escritura,
  input  logic [7:0] in_ad_bus,
  output logic [7:0] out_ad_bus,
  output logic       out_ad_oe,
  output logic       out_cs_n,
  output logic       out_ad_n,
  output logic       out_wr_n,
  output logic       out_rd_n,
  output logic [7:0] out_dato_leido,
  output logic       out_flag_done
);
  state_t state, state_n;
  logic w_r_q;
  logic [7:0] addr_q, data_q, load_val;
  logic zero, load, in_a, in_d, wr_d;
  rtc_bus_timer u_timer (
    .clk(clk), .reset(reset), .load(load), .load_val(load_val), .zero(zero)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = in_en_funcion_rtc ? A_SU : IDLE;
      A_SU:    state_n = zero ? A_PW : A_SU;
      A_PW:    state_n = zero ? A_H  : A_PW;
      A_H:     state_n = zero ? D_SU : A_H;
      D_SU:    state_n = zero ? D_PW : D_SU;
      D_PW:    state_n = zero ? D_H  : D_PW;
      D_H:     state_n = zero ? DONE : D_H;
      DONE:    state_n = REC;
      REC:     state_n = zero ? IDLE : REC;
      default: state_n = IDLE;
    endcase
`ifdef RTC_ABORT_EN
    if (in_a && !in_en_funcion_rtc) state_n = REC;
`endif
    load = state_n != state;
    load_val = (state_n == A_SU || state_n == D_SU) ? ticks(T_SU) :
               (state_n == A_PW || state_n == D_PW) ? ticks(T_PW) :
               (state_n == A_H  || state_n == D_H ) ? ticks(T_H)  :
               (state_n == REC) ? ticks(T_REC) : 8'd0;
  end
  assign in_a = state inside {A_SU, A_PW, A_H};
  assign in_d = state inside {D_SU, D_PW, D_H};
  assign wr_d = in_d && w_r_q;
  assign out_cs_n = (in_a || in_d) ? 1'b0 : PIN_IDLE;
  assign out_ad_n = in_a ? 1'b0 : PIN_IDLE;
  assign out_ad_oe = in_a || wr_d;
  assign out_ad_bus = in_a ? addr_q : wr_d ? data_q : 8'h00;
  assign out_wr_n = (state == A_PW || (state == D_PW && w_r_q)) ? 1'b0 : PIN_IDLE;
  assign out_rd_n = (state == D_PW && !w_r_q) ? 1'b0 : PIN_IDLE;
  assign out_flag_done = state == DONE;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      w_r_q <= 1'b0;
      addr_q <= 8'h00;
      data_q <= 8'h00;
      out_dato_leido <= 8'h00;
    end else begin
      state <= state_n;
      if (state == IDLE && in_en_funcion_rtc) begin
        w_r_q <= in_funcion_w_r;
        addr_q <= in_addr_ram_rtc;
        data_q <= in_dato_escritura;
      end
      if (state == D_PW && zero && !w_r_q) out_dato_leido <= in_ad_bus;
    end
endmodule

// File: tb/tb_rtc_bus_transactor.sv
// tb_rtc_bus_transactor: directed self-checking bench for rtc_bus_transactor
module tb_rtc_bus_transactor;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en0 = 1'b0, en1 = 1'b0, w_r = 1'b0, sel = 1'b0;
  logic [7:0] addr = 8'h00, data = 8'h00, ad_in0 = 8'h00, ad_in1 = 8'h00;
  logic [7:0] bus0, bus1, dato0, dato1;
  logic oe0, cs0, adn0, wr0, rd0, done0, oe1, cs1, adn1, wr1, rd1, done1;
  logic m_cs, m_adn, m_wr, m_rd, m_oe, m_done;
  logic [7:0] m_bus;
  logic r_cs[64], r_adn[64], r_wr[64], r_rd[64], r_oe[64];
  logic [7:0] r_bus[64];
  int errs = 0, checks = 0;
  always #5 clk = ~clk;
  rtc_bus_transactor dut (
    .clk(clk), .reset(reset), .in_en_funcion_rtc(en0), .in_funcion_w_r(w_r),
    .in_addr_ram_rtc(addr), .in_dato_escritura(data), .in_ad_bus(ad_in0),
    .out_ad_bus(bus0), .out_ad_oe(oe0), .out_cs_n(cs0), .out_ad_n(adn0),
    .out_wr_n(wr0), .out_rd_n(rd0), .out_dato_leido(dato0), .out_flag_done(done0)
  );
  rtc_bus_transactor #(.T_SU(1), .T_PW(1), .T_H(1), .T_REC(1)) dut1 (
    .clk(clk), .reset(reset), .in_en_funcion_rtc(en1), .in_funcion_w_r(w_r),
    .in_addr_ram_rtc(addr), .in_dato_escritura(data), .in_ad_bus(ad_in1),
    .out_ad_bus(bus1), .out_ad_oe(oe1), .out_cs_n(cs1), .out_ad_n(adn1),
    .out_wr_n(wr1), .out_rd_n(rd1), .out_dato_leido(dato1), .out_flag_done(done1)
  );
  assign m_cs = sel ? cs1 : cs0;
  assign m_adn = sel ? adn1 : adn0;
  assign m_wr = sel ? wr1 : wr0;
  assign m_rd = sel ? rd1 : rd0;
  assign m_oe = sel ? oe1 : oe0;
  assign m_done = sel ? done1 : done0;
  assign m_bus = sel ? bus1 : bus0;

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic record(input int c);
    r_cs[c] = m_cs; r_adn[c] = m_adn; r_wr[c] = m_wr;
    r_rd[c] = m_rd; r_oe[c] = m_oe; r_bus[c] = m_bus;
  endtask

  // Holds en until done; returns the clock (1 = first clock after the sampling edge) of done, -1 if none.
  task automatic run_txn(input logic wr, input logic [7:0] a, input logic [7:0] d,
                         input logic [7:0] rv, output int dclk);
    dclk = -1;
    @(negedge clk);
    w_r = wr; addr = a; data = d;
    if (sel) en1 = 1'b1; else en0 = 1'b1;
    for (int c = 1; c < 60 && dclk < 0; c++) begin
      @(negedge clk);
      if (sel) ad_in1 = m_rd ? 8'hEE : rv; else ad_in0 = m_rd ? 8'hEE : rv;
      record(c);
      if (m_done) begin
        dclk = c;
        en0 = 1'b0; en1 = 1'b0;
      end
    end
    en0 = 1'b0; en1 = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    checks++; if (cs0 !== 1'b1) begin errs++; $display("FAIL reset_cs_n: got %b want 1", cs0); end
    checks++; if ({wr0, rd0, adn0} !== 3'b111) begin errs++; $display("FAIL reset_strobes: got %b want 111", {wr0, rd0, adn0}); end
    checks++; if (oe0 !== 1'b0) begin errs++; $display("FAIL reset_oe: got %b want 0", oe0); end
    checks++; if (bus0 !== 8'h00) begin errs++; $display("FAIL reset_bus: got %h want 00", bus0); end
    checks++; if (dato0 !== 8'h00) begin errs++; $display("FAIL reset_dato: got %h want 00", dato0); end
    checks++; if (done0 !== 1'b0) begin errs++; $display("FAIL reset_done: got %b want 0", done0); end
    @(negedge clk);
    reset = 1'b0;
    idle(2);
    checks++; if ({cs0, oe0, done0} !== 3'b100) begin errs++; $display("FAIL idle_pins: got %b want 100", {cs0, oe0, done0}); end
  endtask

  task automatic test_write;
    int dclk, n;
    run_txn(1'b1, 8'h02, 8'h10, 8'h00, dclk);
    checks++; if (dclk !== 19) begin errs++; $display("FAIL wr_done_clk: got %0d want 19", dclk); end
    n = 0; for (int c = 1; c <= 9; c++) n += (r_wr[c] == 1'b0) ? 1 : 0;
    checks++; if (n !== 5) begin errs++; $display("FAIL wr_a_pw_len: got %0d want 5", n); end
    checks++; if ({r_wr[2], r_wr[3], r_wr[7], r_wr[8]} !== 4'b1001) begin errs++; $display("FAIL wr_a_pw_edges: got %b want 1001", {r_wr[2], r_wr[3], r_wr[7], r_wr[8]}); end
    checks++; if ({r_bus[3], r_adn[3], r_oe[3]} !== {8'h02, 1'b0, 1'b1}) begin errs++; $display("FAIL wr_a_bus: got %h/%b/%b want 02/0/1", r_bus[3], r_adn[3], r_oe[3]); end
    n = 0; for (int c = 10; c <= 18; c++) n += (r_wr[c] == 1'b0) ? 1 : 0;
    checks++; if (n !== 5) begin errs++; $display("FAIL wr_d_pw_len: got %0d want 5", n); end
    checks++; if ({r_wr[11], r_wr[12], r_wr[16], r_wr[17]} !== 4'b1001) begin errs++; $display("FAIL wr_d_pw_edges: got %b want 1001", {r_wr[11], r_wr[12], r_wr[16], r_wr[17]}); end
    checks++; if ({r_bus[12], r_adn[12], r_oe[12], r_cs[12]} !== {8'h10, 1'b1, 1'b1, 1'b0}) begin errs++; $display("FAIL wr_d_bus: got %h/%b/%b/%b want 10/1/1/0", r_bus[12], r_adn[12], r_oe[12], r_cs[12]); end
    checks++; if ({r_cs[19], r_oe[19]} !== 2'b10) begin errs++; $display("FAIL wr_done_pins: got %b want 10", {r_cs[19], r_oe[19]}); end
    checks++; if (dato0 !== 8'h00) begin errs++; $display("FAIL wr_dato: got %h want 00", dato0); end
    idle(6);
  endtask

  task automatic test_read;
    int dclk, n;
    run_txn(1'b0, 8'h21, 8'h99, 8'h45, dclk);
    checks++; if (dclk !== 19) begin errs++; $display("FAIL rd_done_clk: got %0d want 19", dclk); end
    n = 0; for (int c = 1; c <= 19; c++) n += (r_rd[c] == 1'b0) ? 1 : 0;
    checks++; if (n !== 5) begin errs++; $display("FAIL rd_pw_len: got %0d want 5", n); end
    checks++; if ({r_rd[11], r_rd[12], r_rd[16], r_rd[17]} !== 4'b1001) begin errs++; $display("FAIL rd_pw_edges: got %b want 1001", {r_rd[11], r_rd[12], r_rd[16], r_rd[17]}); end
    n = 0; for (int c = 10; c <= 18; c++) n += r_oe[c] ? 1 : 0;
    checks++; if (n !== 0) begin errs++; $display("FAIL rd_oe_d: got %0d clocks driven want 0", n); end
    checks++; if ({r_bus[1], r_oe[1]} !== {8'h21, 1'b1}) begin errs++; $display("FAIL rd_a_bus: got %h/%b want 21/1", r_bus[1], r_oe[1]); end
    checks++; if (dato0 !== 8'h45) begin errs++; $display("FAIL rd_dato: got %h want 45", dato0); end
    idle(6);
  endtask

  task automatic test_back_to_back;
    int d1 = -1, d2 = -1;
    @(negedge clk);
    w_r = 1'b1; addr = 8'h02; data = 8'h55; en0 = 1'b1;
    for (int c = 1; c < 60 && d2 < 0; c++) begin
      @(negedge clk);
      record(c);
      if (done0) begin
        if (d1 < 0) d1 = c; else d2 = c;
        addr = 8'h10;
      end
    end
    en0 = 1'b0;
    checks++; if (d1 !== 19) begin errs++; $display("FAIL b2b_first_done: got %0d want 19", d1); end
    checks++; if (d2 !== 42) begin errs++; $display("FAIL b2b_second_done: got %0d want 42", d2); end
    checks++; if ({r_cs[23], r_cs[24]} !== 2'b10) begin errs++; $display("FAIL b2b_gap: got %b want 10", {r_cs[23], r_cs[24]}); end
    checks++; if (r_bus[24] !== 8'h10) begin errs++; $display("FAIL b2b_addr2: got %h want 10", r_bus[24]); end
    checks++; if (dato0 !== 8'h45) begin errs++; $display("FAIL b2b_dato_kept: got %h want 45", dato0); end
    idle(6);
  endtask

  task automatic test_abort;
    int dclk = -1;
    @(negedge clk);
    w_r = 1'b0; addr = 8'h07; en0 = 1'b1;
    for (int c = 1; c < 40; c++) begin
      @(negedge clk);
      ad_in0 = 8'h77;
      record(c);
      if (c == 4) en0 = 1'b0;
      if (done0 && dclk < 0) dclk = c;
    end
`ifdef RTC_ABORT_EN
    checks++; if (dclk !== -1) begin errs++; $display("FAIL abort_done: got %0d want none", dclk); end
    checks++; if (r_cs[5] !== 1'b1) begin errs++; $display("FAIL abort_cs_n: got %b want 1", r_cs[5]); end
    checks++; if (dato0 !== 8'h45) begin errs++; $display("FAIL abort_dato: got %h want 45", dato0); end
`else
    checks++; if (dclk !== 19) begin errs++; $display("FAIL noabort_done: got %0d want 19", dclk); end
    checks++; if (r_cs[5] !== 1'b0) begin errs++; $display("FAIL noabort_cs_n: got %b want 0", r_cs[5]); end
    checks++; if (dato0 !== 8'h77) begin errs++; $display("FAIL noabort_dato: got %h want 77", dato0); end
`endif
  endtask

  task automatic test_reset_mid;
    int n = 0;
    @(negedge clk);
    w_r = 1'b1; addr = 8'h02; data = 8'h10; en0 = 1'b1;
    repeat (13) @(negedge clk);
    checks++; if (wr0 !== 1'b0) begin errs++; $display("FAIL rst_mid_pre_wr: got %b want 0", wr0); end
    reset = 1'b1;
    en0 = 1'b0;
    #1;
    checks++; if ({cs0, wr0, oe0, done0} !== 4'b1100) begin errs++; $display("FAIL rst_mid_pins: got %b want 1100", {cs0, wr0, oe0, done0}); end
    checks++; if (dato0 !== 8'h00) begin errs++; $display("FAIL rst_mid_dato: got %h want 00", dato0); end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      n += (done0 || !cs0) ? 1 : 0;
    end
    checks++; if (n !== 0) begin errs++; $display("FAIL rst_mid_idle: got %0d active clocks want 0", n); end
  endtask

  task automatic test_fast;
    int dclk;
    sel = 1'b1;
    run_txn(1'b0, 8'h33, 8'h00, 8'h5A, dclk);
    checks++; if (dclk !== 7) begin errs++; $display("FAIL fast_done_clk: got %0d want 7", dclk); end
    checks++; if ({r_rd[4], r_rd[5], r_rd[6]} !== 3'b101) begin errs++; $display("FAIL fast_rd: got %b want 101", {r_rd[4], r_rd[5], r_rd[6]}); end
    checks++; if (r_wr[2] !== 1'b0) begin errs++; $display("FAIL fast_a_pw: got %b want 0", r_wr[2]); end
    checks++; if (dato1 !== 8'h5A) begin errs++; $display("FAIL fast_dato: got %h want 5a", dato1); end
    sel = 1'b0;
    idle(3);
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_back_to_back;
    test_abort;
    test_reset_mid;
    test_fast;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
